// File: rtl/workout_time_calc_seq_if.sv
// Request/result handshake bundle for workout_time_calc_seq.
// The slave modport is the calculator; the master modport is its producer/consumer.
interface workout_time_calc_seq_if #(
  parameter int unsigned WEIGHT_W = 8,
  parameter int unsigned CAL_W    = 10,
  parameter int unsigned MET_W    = 4,
  parameter int unsigned OUT_W    = 8
);
  logic                in_valid;
  logic                in_ready;
  logic [WEIGHT_W-1:0] weight_kg;
  logic [CAL_W-1:0]    calories;
  logic [MET_W-1:0]    met;
  logic                gender;
  logic                out_valid;
  logic                out_ready;
  logic [OUT_W-1:0]    out_min;
  logic                out_sat;
  logic                out_err;
  logic                busy;

  modport slave (
    input  in_valid, weight_kg, calories, met, gender, out_ready,
    output in_ready, out_valid, out_min, out_sat, out_err, busy
  );

  modport master (
    output in_valid, weight_kg, calories, met, gender, out_ready,
    input  in_ready, out_valid, out_min, out_sat, out_err, busy
  );
endinterface

// File: rtl/workout_time_calc_seq.sv
// Sequential workout-time calculator: minutes = floor(cal*3200 / (7*met*kg*g)) via restoring divider.
// Define WTC_ROUND_EN to add D/2 to the dividend for round-half-up minutes.
module workout_time_calc_seq #(
  parameter int unsigned WEIGHT_W = 8,
  parameter int unsigned CAL_W    = 10,
  parameter int unsigned MET_W    = 4,
  parameter int unsigned OUT_W    = 8
) (
  input logic                   clk,
  input logic                   rst,
  workout_time_calc_seq_if.slave bus
);
  localparam int unsigned NUM_W = CAL_W + 13;
  localparam int unsigned DEN_W = WEIGHT_W + MET_W + 7;
  localparam int unsigned CNT_W = $clog2(NUM_W);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t              state;
  logic [WEIGHT_W-1:0] weight_r;
  logic [CAL_W-1:0]    cal_r;
  logic [MET_W-1:0]    met_r;
  logic                gender_r;
  logic [NUM_W-1:0]    num_r;
  logic [DEN_W-1:0]    den_r;
  logic [DEN_W-1:0]    rem_r;
  logic [CNT_W-1:0]    count;
  logic                err_r;
  logic                out_valid_r;
  logic [OUT_W-1:0]    out_min_r;
  logic                out_sat_r;
  logic                out_err_r;

  logic [DEN_W-1:0]    den_calc;
  logic [NUM_W-1:0]    num_base;
  logic [NUM_W-1:0]    num_calc;
  logic [DEN_W:0]      shifted;
  logic [DEN_W:0]      diff;
  logic                q_bit;
  logic [DEN_W-1:0]    rem_next;
  logic                q_over;

  always_comb begin
    den_calc = DEN_W'(met_r) * DEN_W'(weight_r) * (gender_r ? DEN_W'(63) : DEN_W'(56));
    num_base = NUM_W'(cal_r) * NUM_W'(3200);
`ifdef WTC_ROUND_EN
    num_calc = num_base + NUM_W'(den_calc >> 1);
`else
    num_calc = num_base;
`endif
  end

  // num_r starts as the dividend and is shifted left, collecting quotient bits at the LSB.
  always_comb begin
    shifted  = {rem_r, num_r[NUM_W-1]};
    diff     = shifted - {1'b0, den_r};
    q_bit    = (shifted >= {1'b0, den_r});
    rem_next = q_bit ? diff[DEN_W-1:0] : shifted[DEN_W-1:0];
    q_over   = |num_r[NUM_W-1:OUT_W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      weight_r    <= '0;
      cal_r       <= '0;
      met_r       <= '0;
      gender_r    <= 1'b0;
      num_r       <= '0;
      den_r       <= '0;
      rem_r       <= '0;
      count       <= '0;
      err_r       <= 1'b0;
      out_valid_r <= 1'b0;
      out_min_r   <= '0;
      out_sat_r   <= 1'b0;
      out_err_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            weight_r <= bus.weight_kg;
            cal_r    <= bus.calories;
            met_r    <= bus.met;
            gender_r <= bus.gender;
            state    <= MUL;
          end
        end
        MUL: begin
          den_r <= den_calc;
          num_r <= num_calc;
          rem_r <= '0;
          if (den_calc == '0) begin
            err_r <= 1'b1;
            state <= DONE;
          end else begin
            err_r <= 1'b0;
            count <= CNT_W'(NUM_W - 1);
            state <= DIV;
          end
        end
        DIV: begin
          rem_r <= rem_next;
          num_r <= {num_r[NUM_W-2:0], q_bit};
          count <= count - 1'b1;
          if (count == '0) state <= DONE;
        end
        DONE: begin
          // First DONE cycle registers the result; later cycles wait for the consumer.
          if (!out_valid_r) begin
            out_valid_r <= 1'b1;
            out_err_r   <= err_r;
            if (err_r) begin
              out_min_r <= '1;
              out_sat_r <= 1'b0;
            end else begin
              out_min_r <= q_over ? '1 : num_r[OUT_W-1:0];
              out_sat_r <= q_over;
            end
          end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.out_valid = out_valid_r;
  assign bus.out_min   = out_min_r;
  assign bus.out_sat   = out_sat_r;
  assign bus.out_err   = out_err_r;
endmodule

// File: tb/tb_workout_time_calc_seq.sv
// Scoreboard bench for workout_time_calc_seq: directed cases plus randomized requests
// checked against an arithmetic reference model.
module tb_workout_time_calc_seq;
  localparam int NUM_W = 23;

  typedef struct {
    int min;
    int sat;
    int err;
    int lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  workout_time_calc_seq_if #(.WEIGHT_W(8), .CAL_W(10), .MET_W(4), .OUT_W(8)) bus ();

  workout_time_calc_seq #(.WEIGHT_W(8), .CAL_W(10), .MET_W(4), .OUT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t sb[$];
  int   acc_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  bit   rand_rdy = 1'b0;

  always @(posedge clk) cyc++;

  function automatic exp_t model(int w, int cal, int met, int g);
    exp_t e;
    int d, n, q;
    d = 7 * met * w * (g != 0 ? 9 : 8);
    n = cal * 3200;
    if (d == 0) begin
      e.min = 255; e.sat = 0; e.err = 1; e.lat = 2;
      return e;
    end
`ifdef WTC_ROUND_EN
    n = n + d / 2;
`endif
    q = n / d;
    e.sat = (q > 255) ? 1 : 0;
    e.min = (q > 255) ? 255 : q;
    e.err = 0;
    e.lat = NUM_W + 2;
    return e;
  endfunction

  task automatic check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic issue(int w, int cal, int met, int g);
    int n;
    bus.weight_kg = 8'(w);
    bus.calories  = 10'(cal);
    bus.met       = 4'(met);
    bus.gender    = 1'(g);
    sb.push_back(model(w, cal, met, g));
    bus.in_valid  = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 200) begin
      tick();
      n++;
    end
    if (!bus.in_ready) check("accept_timeout", 0, 1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      tick();
      n++;
    end
    if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
  endtask

  // Monitor: samples on the falling edge, away from the DUT's active edge.
  bit       prev_v = 1'b0;
  bit       stalled = 1'b0;
  int       pm, ps, pe;
  always @(negedge clk) begin
    exp_t e;
    int   a;
    if (rst) begin
      prev_v  = 1'b0;
      stalled = 1'b0;
    end else begin
      if (bus.in_valid && bus.in_ready) acc_q.push_back(cyc + 1);
      if (stalled) begin
        check("valid_held", int'(bus.out_valid), 1);
        check("stall_min", int'(bus.out_min), pm);
        check("stall_sat", int'(bus.out_sat), ps);
        check("stall_err", int'(bus.out_err), pe);
      end
      if (bus.out_valid) check("in_ready_in_done", int'(bus.in_ready), 0);
      if (bus.out_valid && !prev_v) begin
        if (sb.size() == 0 || acc_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_output: got out_valid=1 expected no pending result (t=%0t)", $time);
        end else begin
          a = acc_q.pop_front();
          check("latency", cyc - a, sb[0].lat);
        end
      end
      if (bus.out_valid && bus.out_ready && sb.size() != 0) begin
        e = sb.pop_front();
        check("out_min", int'(bus.out_min), e.min);
        check("out_sat", int'(bus.out_sat), e.sat);
        check("out_err", int'(bus.out_err), e.err);
      end
      stalled = bus.out_valid && !bus.out_ready;
      pm      = int'(bus.out_min);
      ps      = int'(bus.out_sat);
      pe      = int'(bus.out_err);
      prev_v  = bus.out_valid;
    end
  end

  initial begin
    int n, w, met;
    bus.in_valid  = 1'b0;
    bus.weight_kg = '0;
    bus.calories  = '0;
    bus.met       = '0;
    bus.gender    = 1'b0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_min", int'(bus.out_min), 0);
    check("rst_out_sat", int'(bus.out_sat), 0);
    check("rst_out_err", int'(bus.out_err), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_in_ready", int'(bus.in_ready), 1);
    rst = 1'b0;
    tick();

    issue(50, 50, 1, 0);
    wait_drain();
    check("case1_min", int'(bus.out_min), 57);

    issue(120, 200, 8, 1);
    wait_drain();
`ifdef WTC_ROUND_EN
    check("case2_min", int'(bus.out_min), 11);
`else
    check("case2_min", int'(bus.out_min), 10);
`endif

    issue(50, 1023, 1, 0);
    wait_drain();
    check("case3_min", int'(bus.out_min), 255);
    check("case3_sat", int'(bus.out_sat), 1);

    issue(70, 100, 0, 0);
    wait_drain();
    check("met0_err", int'(bus.out_err), 1);
    issue(0, 100, 5, 1);
    wait_drain();
    check("w0_err", int'(bus.out_err), 1);
    check("w0_min", int'(bus.out_min), 255);

    // Stalled consumer with a second request held pending.
    bus.out_ready = 1'b0;
    issue(50, 50, 1, 0);
    bus.weight_kg = 8'd120;
    bus.calories  = 10'd200;
    bus.met       = 4'd8;
    bus.gender    = 1'b1;
    sb.push_back(model(120, 200, 8, 1));
    bus.in_valid  = 1'b1;
    n = 0;
    while (!bus.out_valid && n < 100) begin
      tick();
      n++;
    end
    check("stall_valid_seen", int'(bus.out_valid), 1);
    repeat (5) tick();
    check("stall_in_ready", int'(bus.in_ready), 0);
    bus.out_ready = 1'b1;
    tick();
    check("in_ready_after_hs", int'(bus.in_ready), 1);
    tick();
    bus.in_valid = 1'b0;
    check("pending_accepted", int'(bus.busy), 1);
    wait_drain();

    // Reset in the middle of the divide.
    issue(50, 50, 1, 0);
    repeat (11) tick();
    check("mid_div_busy", int'(bus.busy), 1);
    rst = 1'b1;
    #1;
    check("abort_out_valid", int'(bus.out_valid), 0);
    check("abort_busy", int'(bus.busy), 0);
    check("abort_in_ready", int'(bus.in_ready), 1);
    sb.delete();
    acc_q.delete();
    repeat (2) tick();
    rst = 1'b0;
    tick();
    issue(120, 200, 8, 1);
    wait_drain();

    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      w   = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 255));
      met = int'($urandom_range(0, 15));
      issue(w, int'($urandom_range(0, 1023)), met, int'($urandom_range(0, 1)));
    end
    rand_rdy = 1'b0;
    bus.out_ready = 1'b1;
    wait_drain();
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
